// File: rtl/grad_xyz_pack.sv
// Packs the X/Y/Z gradient lanes (32 bits each) into one PW-bit LII word, with a frame counter.
// Define GRAD_XYZ_PACK_SKID_EN to use a 2-entry skid FIFO output stage, which decouples input tready from output tready.
module grad_xyz_pack #(
    parameter int unsigned PW          = 128,
    parameter logic [7:0]  SRC_ID      = 8'd0,
    parameter logic [7:0]  DST_ID      = 8'd1,
    parameter logic [15:0] FRAME_WORDS = 16'd1024
) (
    input  logic          aclk,
    input  logic          arst,
    input  logic [31:0]   gradient_x_stream_tdata,
    input  logic          gradient_x_stream_tvalid,
    output logic          gradient_x_stream_tready,
    input  logic [31:0]   gradient_y_stream_tdata,
    input  logic          gradient_y_stream_tvalid,
    output logic          gradient_y_stream_tready,
    input  logic [31:0]   gradient_z_stream_tdata,
    input  logic          gradient_z_stream_tvalid,
    output logic          gradient_z_stream_tready,
    output logic [PW-1:0] lii_out_p0_tdata,
    output logic          lii_out_p0_tvalid,
    input  logic          lii_out_p0_tready,
    output logic [7:0]    lii_out_p0_src,
    output logic [7:0]    lii_out_p0_dst,
    output logic          frame_done,
    output logic          ce
);

    logic [2:0]       lane_valid_s;
    logic [2:0][31:0] lane_data_s;
    logic [2:0]       lane_ready_s;
    logic [2:0]       lane_cap_s;
    logic [2:0][31:0] lane_q;
    logic [2:0][31:0] lane_d;
    logic [2:0]       full_q;
    logic [2:0]       full_d;
    logic             out_accept_s;
    logic             pack_fire_s;
    logic [PW-1:0]    packed_s;
    logic             out_hs_s;
    logic [15:0]      frame_cnt_q;
    logic [15:0]      frame_cnt_d;
    logic             frame_done_q;
    logic             frame_done_d;

    assign lane_valid_s = {gradient_z_stream_tvalid, gradient_y_stream_tvalid, gradient_x_stream_tvalid};
    assign lane_data_s  = {gradient_z_stream_tdata, gradient_y_stream_tdata, gradient_x_stream_tdata};

    assign gradient_x_stream_tready = lane_ready_s[0];
    assign gradient_y_stream_tready = lane_ready_s[1];
    assign gradient_z_stream_tready = lane_ready_s[2];
    assign ce                       = &lane_ready_s;

    assign lii_out_p0_src = SRC_ID;
    assign lii_out_p0_dst = DST_ID;
    assign frame_done     = frame_done_q;

    // Lane capture: a full lane only reopens in the cycle its contents are packed.
    always_comb begin
        pack_fire_s = (&full_q) & out_accept_s;
        for (int i = 0; i < 3; i++) begin
            lane_ready_s[i] = ~full_q[i] | pack_fire_s;
            lane_cap_s[i]   = lane_valid_s[i] & lane_ready_s[i];
            if (lane_cap_s[i]) begin
                full_d[i] = 1'b1;
                lane_d[i] = lane_data_s[i];
            end else if (pack_fire_s) begin
                full_d[i] = 1'b0;
                lane_d[i] = lane_q[i];
            end else begin
                full_d[i] = full_q[i];
                lane_d[i] = lane_q[i];
            end
        end
    end

    // Word assembly: X in the low bits, zero padding above Z.
    always_comb begin
        packed_s        = '0;
        packed_s[95:0]  = {lane_q[2], lane_q[1], lane_q[0]};
    end

    // Lane registers and full flags.
    always_ff @(posedge aclk) begin
        if (arst) begin
            lane_q <= '0;
            full_q <= 3'b000;
        end else begin
            lane_q <= lane_d;
            full_q <= full_d;
        end
    end

`ifdef GRAD_XYZ_PACK_SKID_EN
    logic [PW-1:0] skid0_q;
    logic [PW-1:0] skid0_d;
    logic [PW-1:0] skid1_q;
    logic [PW-1:0] skid1_d;
    logic [1:0]    skid_cnt_q;
    logic [1:0]    skid_cnt_d;
    logic          skid_pop_s;

    // Acceptance depends only on the registered occupancy, so tready never reaches the lanes.
    assign out_accept_s      = (skid_cnt_q != 2'd2);
    assign skid_pop_s        = (skid_cnt_q != 2'd0) & lii_out_p0_tready;
    assign lii_out_p0_tvalid = (skid_cnt_q != 2'd0);
    assign lii_out_p0_tdata  = skid0_q;

    // Skid FIFO next state; skid0 is always the head presented on the output.
    always_comb begin
        skid0_d    = skid0_q;
        skid1_d    = skid1_q;
        skid_cnt_d = skid_cnt_q;
        case ({pack_fire_s, skid_pop_s})
            2'b10: begin
                if (skid_cnt_q == 2'd0) begin
                    skid0_d = packed_s;
                end else begin
                    skid1_d = packed_s;
                end
                skid_cnt_d = skid_cnt_q + 2'd1;
            end
            2'b01: begin
                skid0_d    = skid1_q;
                skid_cnt_d = skid_cnt_q - 2'd1;
            end
            2'b11: begin
                if (skid_cnt_q == 2'd1) begin
                    skid0_d = packed_s;
                end else begin
                    skid0_d = skid1_q;
                    skid1_d = packed_s;
                end
            end
            default: begin
                skid_cnt_d = skid_cnt_q;
            end
        endcase
    end

    // Skid FIFO storage.
    always_ff @(posedge aclk) begin
        if (arst) begin
            skid0_q    <= '0;
            skid1_q    <= '0;
            skid_cnt_q <= 2'd0;
        end else begin
            skid0_q    <= skid0_d;
            skid1_q    <= skid1_d;
            skid_cnt_q <= skid_cnt_d;
        end
    end
`else
    logic [PW-1:0] out_data_q;
    logic [PW-1:0] out_data_d;
    logic          out_valid_q;
    logic          out_valid_d;

    assign out_accept_s      = ~out_valid_q | lii_out_p0_tready;
    assign lii_out_p0_tvalid = out_valid_q;
    assign lii_out_p0_tdata  = out_data_q;

    // Single output register next state.
    always_comb begin
        if (pack_fire_s) begin
            out_valid_d = 1'b1;
            out_data_d  = packed_s;
        end else if (lii_out_p0_tready) begin
            out_valid_d = 1'b0;
            out_data_d  = out_data_q;
        end else begin
            out_valid_d = out_valid_q;
            out_data_d  = out_data_q;
        end
    end

    // Output register.
    always_ff @(posedge aclk) begin
        if (arst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end
`endif

    assign out_hs_s = lii_out_p0_tvalid & lii_out_p0_tready;

    // Frame counter: wraps on the FRAME_WORDS-th handshake and pulses frame_done next cycle.
    always_comb begin
        if (out_hs_s) begin
            if (frame_cnt_q == (FRAME_WORDS - 16'd1)) begin
                frame_cnt_d  = 16'd0;
                frame_done_d = 1'b1;
            end else begin
                frame_cnt_d  = frame_cnt_q + 16'd1;
                frame_done_d = 1'b0;
            end
        end else begin
            frame_cnt_d  = frame_cnt_q;
            frame_done_d = 1'b0;
        end
    end

    // Frame counter and pulse registers.
    always_ff @(posedge aclk) begin
        if (arst) begin
            frame_cnt_q  <= 16'd0;
            frame_done_q <= 1'b0;
        end else begin
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: doc/grad_xyz_pack.md
GRAD_XYZ_PACK -- requirements
Module: grad_xyz_pack

Interface
REQ-001 SHALL have parameter PW, default 128, LII phy packing width (min 96).
REQ-002 SHALL have parameter SRC_ID, default 8'd0, constant on lii_out_p0_src.
REQ-003 SHALL have parameter DST_ID, default 8'd1, constant on lii_out_p0_dst.
REQ-004 SHALL have parameter FRAME_WORDS, default 16'd1024, packed words per frame (1..65535).
REQ-005 SHALL have ports: aclk  in  1  sole clock, rising edge; arst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports gradient_x_stream_tdata/tvalid/tready  in/in/out  32/1/1  lane X from gradient kernel; gradient_y_* and gradient_z_* identical for lanes Y and Z.
REQ-007 SHALL have ports lii_out_p0_tdata/tvalid/tready  out/out/in  PW/1/1  packed LII output; lii_out_p0_src, lii_out_p0_dst  out  8 each.
REQ-008 SHALL have ports frame_done  out  1  one-cycle frame pulse; ce  out  1  clock enable to gradient kernel.

Function
REQ-009 SHALL hold one 32-bit register plus full flag per lane; lane tready = !full | pack_fire; capture on tvalid&tready.
REQ-010 SHALL assert pack_fire when all three full flags are set and the output stage can accept a word.
REQ-011 On pack_fire SHALL form word: [31:0]=X, [63:32]=Y, [95:64]=Z, [PW-1:96]=0; full flags clear unless the same lane captures that cycle.
REQ-012 SHALL let lanes arrive in any order/cycle; a full lane SHALL stall (tready=0) until pack_fire.
REQ-013 SHALL sustain one packed word per cycle when all lanes are valid every cycle and lii_out_p0_tready=1.
REQ-014 Latency SHALL be 2 cycles from the last lane handshake to lii_out_p0_tvalid (capture, then output register).
REQ-015 lii_out_p0_tvalid, once high, SHALL stay high with tdata stable until lii_out_p0_tready=1.
REQ-016 No word SHALL be dropped, duplicated or reordered; lane data SHALL never mix across words.
REQ-017 lii_out_p0_src/dst SHALL equal SRC_ID/DST_ID at all times, including reset.
REQ-018 SHALL count output handshakes in a 16-bit counter; on the FRAME_WORDS-th handshake frame_done=1 for exactly the next cycle and the counter returns to 0.
REQ-019 FRAME_WORDS=1 SHALL pulse frame_done after every handshake; back-to-back frames SHALL give back-to-back pulses.
REQ-020 ce SHALL equal gradient_x_stream_tready & gradient_y_stream_tready & gradient_z_stream_tready.

Reset
REQ-021 While arst=1 at a rising edge: full flags 0, lane registers 0, lii_out_p0_tvalid 0, lii_out_p0_tdata 0, frame counter 0, frame_done 0.
REQ-022 Reset mid-operation SHALL discard partially assembled and pending output words; no word SHALL emerge after reset unless new inputs arrive.
REQ-023 All lane treadys SHALL be 1 and ce SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-024 Macro GRAD_XYZ_PACK_SKID_EN SHALL select the output stage.
REQ-025 Without it: single output register; output accepts when !tvalid | lii_out_p0_tready (combinational path from lii_out_p0_tready to lane treadys).
REQ-026 With it: 2-entry skid FIFO; output accepts when FIFO holds <2 entries, using registered state only; no combinational path from lii_out_p0_tready to any input tready; REQ-013/014/015 SHALL still hold.

Verification
REQ-027 Reset, then X=0x11111111, Y=0x22222222, Z=0x33333333 same cycle, tready=1 -> tvalid 2 cycles later, tdata=0x00000000_33333333_22222222_11111111, src=0x00, dst=0x01.
REQ-028 X at t0, Z at t3, Y at t6 -> X/Z treadys low from capture until pack_fire; one word from those values; no earlier output.
REQ-029 Continuous valid on all lanes, lii_out_p0_tready=1 for 100 cycles -> 1 word/cycle after latency, data in order, ce=1 throughout.
REQ-030 lii_out_p0_tready=0 for 10 cycles with lanes streaming -> tdata stable, ce=0 once all buffers fill, no loss when released.
REQ-031 FRAME_WORDS=4, 9 words drained -> frame_done high the cycle after the 4th and 8th handshakes only.
REQ-032 arst asserted with lane X full and an output word pending -> tvalid=0 next cycle; lanes Y,Z alone then never yield a word.
